// File: rtl/fp16_pkg.sv
// Shared FP16 constants, the divider state encoding and the result-class flag struct.
package fp16_pkg;

    localparam int         BIAS         = 15;
    localparam int         QBITS        = 12;
    localparam logic [4:0] EXP_MAX      = 5'h1F;
    localparam logic [9:0] QNAN_PAYLOAD = 10'h200;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        PACK,
        DONE
    } state_t;

    typedef struct packed {
        logic snan;
        logic qnan;
        logic inf;
        logic zero;
        logic normal;
    } flags_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational IEEE-754 binary16 operand classifier; exactly one output is high.
module fp16_classify (
    input  logic [15:0] x,
    output logic        snan,
    output logic        qnan,
    output logic        inf,
    output logic        zero,
    output logic        subnormal,
    output logic        normal
);
    import fp16_pkg::*;

    logic exp_max;
    logic exp_zero;
    logic frac_zero;

    always_comb begin
        exp_max   = (x[14:10] == EXP_MAX);
        exp_zero  = (x[14:10] == 5'h00);
        frac_zero = (x[9:0] == 10'h000);
        snan      = exp_max & ~frac_zero & ~x[9];
        qnan      = exp_max & ~frac_zero &  x[9];
        inf       = exp_max &  frac_zero;
        zero      = exp_zero &  frac_zero;
        subnormal = exp_zero & ~frac_zero;
        normal    = ~exp_max & ~exp_zero;
    end

endmodule

// File: rtl/fp16_div_seq.sv
// Sequential FP16 divider (restoring, one quotient bit per clock) with start/busy/done handshake.
// Define FP16_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp16_div_seq
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] na,
    input  logic [15:0] nb,
    output logic [15:0] quotient,
    output logic        busy,
    output logic        done,
    output logic        snan,
    output logic        qnan,
    output logic        inf,
    output logic        zero,
    output logic        normal,
    output logic        div_by_zero
);

`ifdef FP16_DIV_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif
    localparam logic signed [6:0] BIAS7 = 7'(BIAS);

    state_t              state_q, state_d;
    logic [15:0]         a_q, a_d, b_q, b_d, quot_q, quot_d;
    logic [11:0]         rem_q, rem_d;
    logic [QBITS-1:0]    q_q, q_d;
    logic [3:0]          cnt_q, cnt_d;
    logic signed [6:0]   e_q, e_d;
    logic                busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    flags_t              flags_q, flags_d;

    logic a_snan, a_qnan, a_inf, a_zero, a_sub, a_norm;
    logic b_snan, b_qnan, b_inf, b_zero, b_sub, b_norm;

    fp16_classify u_cls_a (
        .x(a_q), .snan(a_snan), .qnan(a_qnan), .inf(a_inf),
        .zero(a_zero), .subnormal(a_sub), .normal(a_norm)
    );
    fp16_classify u_cls_b (
        .x(b_q), .snan(b_snan), .qnan(b_qnan), .inf(b_inf),
        .zero(b_zero), .subnormal(b_sub), .normal(b_norm)
    );

    logic              sign, a_z, b_z, qbit, round_up, carry;
    logic [10:0]       ma, mb;
    logic [11:0]       rem_t;
    logic [9:0]        frac;
    logic signed [6:0] e_pre, e_r;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        flags_d = flags_q;

        sign  = a_q[15] ^ b_q[15];
        a_z   = a_zero | a_sub;
        b_z   = b_zero | b_sub;
        ma    = {1'b1, a_q[9:0]};
        mb    = {1'b1, b_q[9:0]};
        e_pre = $signed({2'b00, a_q[14:10]}) - $signed({2'b00, b_q[14:10]}) + BIAS7;

        qbit  = (rem_q >= {1'b0, mb});
        rem_t = qbit ? rem_q - {1'b0, mb} : rem_q;

        // Carry out of the increment wraps frac to zero, which is exactly the required mantissa.
        round_up = ROUND_EN & q_q[0] & ((|rem_q) | q_q[1]);
        carry    = (&q_q[11:1]) & round_up;
        frac     = q_q[10:1] + {9'b0, round_up};
        e_r      = carry ? e_q + 7'sd1 : e_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = na;
                    b_d     = nb;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                state_d = DONE;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                flags_d = '0;
                if (a_snan) begin
                    quot_d       = a_q;
                    flags_d.snan = 1'b1;
                end else if (b_snan) begin
                    quot_d       = b_q;
                    flags_d.snan = 1'b1;
                end else if (a_qnan) begin
                    quot_d       = a_q;
                    flags_d.qnan = 1'b1;
                end else if (b_qnan) begin
                    quot_d       = b_q;
                    flags_d.qnan = 1'b1;
                end else if (a_norm && b_norm) begin
                    // NaNs are excluded above and inf/zero operands are never both-normal,
                    // so taking this branch early does not reorder any special case.
                    state_d = DIV;
                    done_d  = 1'b0;
                    dbz_d   = dbz_q;
                    flags_d = flags_q;
                    q_d     = '0;
                    cnt_d   = 4'(QBITS - 1);
                    if (ma < mb) begin
                        rem_d = {ma, 1'b0};
                        e_d   = e_pre - 7'sd1;
                    end else begin
                        rem_d = {1'b0, ma};
                        e_d   = e_pre;
                    end
                end else if ((a_inf && b_inf) || (a_z && b_z)) begin
                    quot_d       = {sign, EXP_MAX, QNAN_PAYLOAD};
                    flags_d.qnan = 1'b1;
                end else if (a_inf) begin
                    quot_d      = {sign, EXP_MAX, 10'h000};
                    flags_d.inf = 1'b1;
                end else if (b_inf) begin
                    quot_d       = {sign, 15'h0000};
                    flags_d.zero = 1'b1;
                end else if (b_z) begin
                    quot_d      = {sign, EXP_MAX, 10'h000};
                    flags_d.inf = 1'b1;
                    dbz_d       = 1'b1;
                end else begin
                    quot_d       = {sign, 15'h0000};
                    flags_d.zero = 1'b1;
                end
            end
            DIV: begin
                q_d   = {q_q[QBITS-2:0], qbit};
                rem_d = {rem_t[10:0], 1'b0};
                if (cnt_q == 4'd0) begin
                    state_d = PACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            PACK: begin
                state_d = DONE;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                flags_d = '0;
                if (e_r > 7'sd30) begin
                    quot_d      = {sign, EXP_MAX, 10'h000};
                    flags_d.inf = 1'b1;
                end else if (e_r < 7'sd1) begin
                    quot_d       = {sign, 15'h0000};
                    flags_d.zero = 1'b1;
                end else begin
                    quot_d         = {sign, e_r[4:0], frac};
                    flags_d.normal = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            e_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            flags_q <= flags_d;
        end
    end

    assign quotient    = quot_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign snan        = flags_q.snan;
    assign qnan        = flags_q.qnan;
    assign inf         = flags_q.inf;
    assign zero        = flags_q.zero;
    assign normal      = flags_q.normal;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Self-checking bench for fp16_div_seq: directed cases, handshake/reset cases and random operands vs. an arithmetic model.
module tb_fp16_div_seq;

    localparam logic [4:0] F_SN  = 5'b10000;
    localparam logic [4:0] F_QN  = 5'b01000;
    localparam logic [4:0] F_INF = 5'b00100;
    localparam logic [4:0] F_Z   = 5'b00010;
    localparam logic [4:0] F_N   = 5'b00001;

`ifdef FP16_DIV_ROUND_EN
    localparam logic [15:0] Q_5_3 = 16'h3EAB;
    localparam bit          RND   = 1'b1;
`else
    localparam logic [15:0] Q_5_3 = 16'h3EAA;
    localparam bit          RND   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] na = '0;
    logic [15:0] nb = '0;
    logic [15:0] quotient;
    logic        busy, done, snan, qnan, inf, zero, normal, div_by_zero;

    int total = 0;
    int bad   = 0;
    logic [15:0] prev_q = '0;

    fp16_div_seq dut (
        .clk(clk), .rst(rst), .start(start), .na(na), .nb(nb),
        .quotient(quotient), .busy(busy), .done(done),
        .snan(snan), .qnan(qnan), .inf(inf), .zero(zero), .normal(normal),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] flags_now();
        return {snan, qnan, inf, zero, normal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient of the significands, then round/pack by the format rules.
    task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [4:0] f,
                           output logic dbz, output int lat);
        int ea, eb, ma, mb, e, num, qq, rem, frac;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic s;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        a_nan  = (ea == 31) && (a[9:0] != 0);
        b_nan  = (eb == 31) && (b[9:0] != 0);
        a_inf  = (ea == 31) && (a[9:0] == 0);
        b_inf  = (eb == 31) && (b[9:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        s   = a[15] ^ b[15];
        dbz = 1'b0;
        lat = 1;
        if (a_nan && !a[9])                         begin q = a; f = F_SN; end
        else if (b_nan && !b[9])                    begin q = b; f = F_SN; end
        else if (a_nan)                             begin q = a; f = F_QN; end
        else if (b_nan)                             begin q = b; f = F_QN; end
        else if ((a_inf && b_inf) || (a_zero && b_zero)) begin q = {s, 15'h7E00}; f = F_QN; end
        else if (a_inf)                             begin q = {s, 15'h7C00}; f = F_INF; end
        else if (b_inf)                             begin q = {s, 15'h0000}; f = F_Z; end
        else if (b_zero)                            begin q = {s, 15'h7C00}; f = F_INF; dbz = 1'b1; end
        else if (a_zero)                            begin q = {s, 15'h0000}; f = F_Z; end
        else begin
            lat = 14;
            ma = 1024 + int'(a[9:0]);
            mb = 1024 + int'(b[9:0]);
            e  = ea - eb + 15;
            if (ma >= mb) num = ma * 2048;
            else begin num = ma * 4096; e = e - 1; end
            qq   = num / mb;
            rem  = num % mb;
            frac = qq / 2;
            if (RND && (qq % 2 == 1) && (rem != 0 || frac % 2 == 1)) frac++;
            if (frac == 2048) begin frac = 1024; e++; end
            if (e > 30)      begin q = {s, 15'h7C00}; f = F_INF; end
            else if (e < 1)  begin q = {s, 15'h0000}; f = F_Z; end
            else             begin q = {s, 5'(e), 10'(frac)}; f = F_N; end
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_q, input logic [4:0] exp_f,
                          input logic exp_dbz, input int exp_lat);
        int lat;
        @(negedge clk);
        na = a; nb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        na = 16'($urandom);
        nb = 16'($urandom);
        chk({tag, ":busy"}, 32'(busy), 32'd1);
        chk({tag, ":hold"}, 32'(quotient), 32'(prev_q));
        wait_done(lat);
        chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":q"}, 32'(quotient), 32'(exp_q));
        chk({tag, ":flags"}, 32'(flags_now()), 32'(exp_f));
        chk({tag, ":dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        @(posedge clk); #1;
        chk({tag, ":end"}, 32'({busy, done}), 32'd0);
        prev_q = exp_q;
    endtask

    initial begin
        logic [15:0] a, b, q;
        logic [4:0]  f;
        logic        d;
        int          l, lat, dones;

        #3;
        chk("reset", 32'({quotient, busy, done, flags_now(), div_by_zero}), 32'd0);
        @(negedge clk) rst = 1'b0;

        run_op("one_half",  16'h3C00, 16'h4000, 16'h3800, F_N,   1'b0, 14);
        run_op("x_div_0",   16'h3C00, 16'h0000, 16'h7C00, F_INF, 1'b1, 1);
        run_op("0_div_0",   16'h0000, 16'h0000, 16'h7E00, F_QN,  1'b0, 1);
        run_op("five_3rd",  16'h4500, 16'h4200, Q_5_3,    F_N,   1'b0, 14);
        run_op("overflow",  16'h7BFF, 16'h0400, 16'h7C00, F_INF, 1'b0, 14);
        run_op("underflow", 16'h0400, 16'h7BFF, 16'h0000, F_Z,   1'b0, 14);
        run_op("snan_a",    16'h7D01, 16'h7E00, 16'h7D01, F_SN,  1'b0, 1);
        run_op("subn_daz",  16'h8200, 16'h3C00, 16'h8000, F_Z,   1'b0, 1);
        run_op("snan_b",    16'h7E00, 16'hFC01, 16'hFC01, F_SN,  1'b0, 1);
        run_op("qnan_b",    16'h3C00, 16'hFE00, 16'hFE00, F_QN,  1'b0, 1);
        run_op("inf_inf",   16'hFC00, 16'h7C00, 16'hFE00, F_QN,  1'b0, 1);
        run_op("inf_x",     16'h7C00, 16'hC000, 16'hFC00, F_INF, 1'b0, 1);
        run_op("inf_0",     16'h7C00, 16'h0000, 16'h7C00, F_INF, 1'b0, 1);
        run_op("x_inf",     16'hC000, 16'h7C00, 16'h8000, F_Z,   1'b0, 1);
        run_op("0_x",       16'h8000, 16'h4000, 16'h8000, F_Z,   1'b0, 1);
        run_op("neg_div",   16'hC600, 16'h4000, 16'hC200, F_N,   1'b0, 14);

        // start reasserted mid-division with new operands must be ignored
        @(negedge clk);
        na = 16'h4500; nb = 16'h4200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        na = 16'h3C00; nb = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("busy_ign:lat", 32'(lat + 4), 32'd14);
        chk("busy_ign:q", 32'(quotient), 32'(Q_5_3));
        chk("busy_ign:flags", 32'(flags_now()), 32'(F_N));

        // start held through DONE: not accepted until the IDLE edge
        na = 16'h3C00; nb = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        chk("b2b:not_acc", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b:acc", 32'(busy), 32'd1);
        wait_done(lat);
        chk("b2b:lat", 32'(lat), 32'd14);
        chk("b2b:q", 32'(quotient), 32'h3800);
        @(posedge clk); #1;
        prev_q = 16'h3800;

        // asynchronous reset during DIV cycle 5
        @(negedge clk);
        na = 16'h4500; nb = 16'h4200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid", 32'({quotient, busy, done, flags_now(), div_by_zero}), 32'd0);
        @(negedge clk) rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        chk("rst_mid:no_done", 32'(dones), 32'd0);
        prev_q = 16'h0000;
        run_op("after_rst", 16'h4500, 16'h4200, Q_5_3, F_N, 1'b0, 14);

        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            ref_div(a, b, q, f, d, l);
            run_op($sformatf("rand%0d_%h_%h", i, a, b), a, b, q, f, d, l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
